// File: rtl/bidir_shift_ctrl.sv
// bidir_shift_ctrl
//   Command sequencer for a bidirectional shift datapath. A command loads a
//   working register and a shift count. The register is then shifted one bit
//   per cycle, left or right, with a serial-in fill bit. The result is
//   returned on a valid/ready response port. The shl/shr strobes mark every
//   cycle in which a shift is actually applied.
//
//   Optional feature: define SHIFT_ROTATE_EN to honour cmd_rot. When it is
//   defined, a rotate command re-inserts the bit that was shifted out instead
//   of the fill bit. When it is undefined, cmd_rot is ignored.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   clear                   synchronous abort: drops any command, zeroes data
//   cmd_valid / cmd_ready   command handshake (ready only while idle)
//   cmd_data                value loaded into the working register
//   cmd_dir                 0 = left (toward MSB), 1 = right
//   cmd_count               number of single-bit shifts
//   cmd_fill                serial-in bit for the vacated end
//   cmd_rot                 rotate request
//   rsp_valid / rsp_ready   response handshake; rsp_data is the register
//   busy                    controller not idle
//   shl / shr               shift strobes
//   clr                     clear delayed by one cycle
module bidir_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic             cmd_rot,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic             shl,
    output logic             shr,
    output logic             clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             fill_q, fill_d;
    logic             clr_q;
    logic             ins_bit;

    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic             dir,
        input logic             ins
    );
        if (dir)
            return {ins, d[WIDTH-1:1]};
        else
            return {d[WIDTH-2:0], ins};
    endfunction

`ifdef SHIFT_ROTATE_EN
    logic rot_q, rot_d;

    // A rotate feeds the outgoing bit back in at the opposite end.
    always_comb begin
        if (rot_q)
            ins_bit = dir_q ? data_q[0] : data_q[WIDTH-1];
        else
            ins_bit = fill_q;
    end
`else
    logic unused_rot;
    assign unused_rot = cmd_rot;
    assign ins_bit    = fill_q;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
`ifdef SHIFT_ROTATE_EN
        rot_d   = rot_q;
`endif
        shl     = 1'b0;
        shr     = 1'b0;

        // Clear wins over everything, so no shift (and no strobe) happens in
        // a cycle where it is asserted.
        if (clear) begin
            state_d = IDLE;
            data_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        data_d  = cmd_data;
                        cnt_d   = cmd_count;
                        dir_d   = cmd_dir;
                        fill_d  = cmd_fill;
`ifdef SHIFT_ROTATE_EN
                        rot_d   = cmd_rot;
`endif
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        data_d = shift_step(data_q, dir_q, ins_bit);
                        cnt_d  = cnt_q - CNT_W'(1);
                        shl    = ~dir_q;
                        shr    = dir_q;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= rot_d;
`endif
            clr_q   <= clear;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = data_q;
    assign clr       = clr_q;

endmodule

// File: tb/tb_bidir_shift_ctrl.sv
// Testbench for bidir_shift_ctrl (WIDTH=4, CNT_W=3).
// A transaction-level model tracks the cycles since acceptance and computes
// the register contents arithmetically. A negedge process compares every
// output against it. Directed transactions with literal results pin the
// model. Randomized traffic (including clears) follows.
module tb_bidir_shift_ctrl;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             cmd_fill = 1'b0;
    logic             cmd_rot = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic             shl;
    logic             shr;
    logic             clr;

    int n_checks = 0;
    int n_fail   = 0;

    bidir_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
        .cmd_rot(cmd_rot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .shl(shl), .shr(shr), .clr(clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result of applying k single-bit shifts to d.
    function automatic int f_apply(input int d, input bit dir, input int k,
                                   input bit fill, input bit rot);
        int mask, r, kk;
        mask = (1 << WIDTH) - 1;
`ifdef SHIFT_ROTATE_EN
        if (rot) begin
            kk = k % WIDTH;
            if (dir) r = ((d >> kk) | (d << (WIDTH - kk))) & mask;
            else     r = ((d << kk) | (d >> (WIDTH - kk))) & mask;
            return r;
        end
`endif
        if (k >= WIDTH) return fill ? mask : 0;
        if (!dir) r = ((d << k) | (fill ? ((1 << k) - 1) : 0)) & mask;
        else      r = (d >> k) | (fill ? (mask & ~(mask >> k)) : 0);
        return r;
    endfunction

    // Model: idle, or busy with m_t = cycles elapsed since the accepting edge.
    // m_t <= m_n: still shifting (m_t shifts applied); m_t == m_n+1: done.
    bit m_busy = 0;
    int m_t = 0, m_ld = 0, m_n = 0, m_idle = 0;
    bit m_dir = 0, m_fill = 0, m_rot = 0, m_clr = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_t = 0; m_idle = 0; m_clr = 0;
        end else begin
            m_clr = clear;
            if (clear) begin
                m_busy = 0; m_idle = 0;
            end else if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy = 1; m_t = 0; m_ld = int'(cmd_data); m_n = int'(cmd_count);
                    m_dir = cmd_dir; m_fill = cmd_fill; m_rot = cmd_rot;
                end
            end else if (m_t <= m_n) begin
                m_t++;
            end else if (rsp_ready) begin
                m_busy = 0;
                m_idle = f_apply(m_ld, m_dir, m_n, m_fill, m_rot);
            end
        end
    end

    // Compare process.
    always @(negedge clk) begin
        int e_data;
        bit e_shift, e_done;
        e_shift = m_busy && (m_t < m_n) && !clear && rst_n;
        e_done  = m_busy && (m_t > m_n);
        e_data  = m_busy ? f_apply(m_ld, m_dir, (m_t < m_n) ? m_t : m_n, m_fill, m_rot) : m_idle;
        chk("cmd_ready", int'(cmd_ready), int'(!m_busy));
        chk("busy",      int'(busy),      int'(m_busy));
        chk("rsp_valid", int'(rsp_valid), int'(e_done));
        chk("rsp_data",  int'(rsp_data),  e_data);
        chk("shl",       int'(shl),       int'(e_shift && !m_dir));
        chk("shr",       int'(shr),       int'(e_shift && m_dir));
        chk("clr",       int'(clr),       int'(m_clr));
    end

    // Directed transaction with literal expectations.
    task automatic do_cmd(input string nm, input logic [3:0] d, input bit dir,
                          input int cnt, input bit fill, input bit rot,
                          input int exp_data, input int exp_lat,
                          input int exp_shl, input int exp_shr, input int hold);
        int lat, nl, nr;
        cmd_data = d; cmd_dir = dir; cmd_count = CNT_W'(cnt);
        cmd_fill = fill; cmd_rot = rot; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0; nl = 0; nr = 0;
        while (lat < 40) begin
            @(negedge clk);
            nl += int'(shl); nr += int'(shr);
            @(posedge clk); #1;
            lat++;
            if (rsp_valid) break;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_data"}, int'(rsp_data), exp_data);
        chk({nm, "_shl_cycles"}, nl, exp_shl);
        chk({nm, "_shr_cycles"}, nr, exp_shr);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, int'(rsp_valid), 1);
            chk({nm, "_hold_data"}, int'(rsp_data), exp_data);
            chk({nm, "_hold_cmd_ready"}, int'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({nm, "_back_idle"}, int'(cmd_ready), 1);
        chk({nm, "_kept_data"}, int'(rsp_data), exp_data);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_cmd("t1", 4'b0101, 0, 1, 0, 0, 4'b1010, 2, 1, 0, 0);
        do_cmd("t2", 4'b1010, 1, 2, 1, 0, 4'b1110, 3, 0, 2, 0);
        do_cmd("t3", 4'b0101, 0, 0, 0, 0, 4'b0101, 1, 0, 0, 0);
        do_cmd("t4", 4'b1111, 0, 7, 0, 0, 4'b0000, 8, 7, 0, 0);
        do_cmd("t6", 4'b0011, 1, 1, 1, 0, 4'b1001, 2, 0, 1, 4);
`ifdef SHIFT_ROTATE_EN
        do_cmd("rot", 4'b1001, 0, 1, 0, 1, 4'b0011, 2, 1, 0, 0);
`else
        do_cmd("rot", 4'b1001, 0, 1, 0, 1, 4'b0010, 2, 1, 0, 0);
`endif

        // Clear in the second SHIFT cycle of a count-5 command.
        cmd_data = 4'b0110; cmd_dir = 0; cmd_count = 3'd5; cmd_fill = 1; cmd_rot = 0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("t5_idle", int'(cmd_ready), 1);
        chk("t5_data", int'(rsp_data), 0);
        chk("t5_clr", int'(clr), 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("t5_no_rsp", int'(rsp_valid), 0);
        end

        // Asynchronous reset in the middle of a command.
        cmd_data = 4'b1100; cmd_dir = 1; cmd_count = 3'd6; cmd_fill = 0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_data", int'(rsp_data), 0);
        chk("arst_ready", int'(cmd_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_data  = 4'($urandom);
            cmd_dir   = 1'($urandom);
            cmd_count = 3'($urandom);
            cmd_fill  = 1'($urandom);
            cmd_rot   = 1'($urandom);
            rsp_ready = 1'($urandom);
            clear     = ($urandom_range(0, 29) == 0);
            @(posedge clk); #1;
        end
        clear = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
